// File: rtl/eprisc_bus_mailbox_pkg.sv
// epRISC_bus_pkg: register map, STATUS/CTRL bit positions and default window base
// shared by the bus mailbox and its bench.
package epRISC_bus_pkg;

   localparam logic [31:0] DEFAULT_BASE = 32'hFFFF_0000;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_RSVD   = 2'd3
   } reg_off_e;

   localparam int ST_RXNE   = 0;
   localparam int ST_TXFULL = 1;
   localparam int ST_RXOVF  = 2;
   localparam int ST_TXOVF  = 3;
   localparam int ST_RXCNT  = 4;
   localparam int ST_TXCNT  = 12;
   localparam int ST_CNTW   = 5;

   localparam int CTRL_RXIE  = 0;
   localparam int CTRL_TXEIE = 1;

endpackage

// File: rtl/eprisc_bus_mailbox_fifo.sv
// epRISC_sync_fifo: single-clock FIFO; a push while full is dropped even if a pop
// happens in the same cycle, so fullness is judged on the pre-pop count.
module epRISC_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                   iClk,
   input  logic                   iRst,
   input  logic                   iPush,
   input  logic                   iPop,
   input  logic [WIDTH-1:0]       iData,
   output logic [WIDTH-1:0]       oData,
   output logic                   oFull,
   output logic                   oEmpty,
   output logic [$clog2(DEPTH):0] oCount
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign oFull   = cnt_q == (AW+1)'(DEPTH);
   assign oEmpty  = cnt_q == '0;
   assign do_push = iPush && !oFull;
   assign do_pop  = iPop && !oEmpty;
   assign oData   = mem_q[rd_q];
   assign oCount  = cnt_q;

   always_comb begin
      wr_d  = iRst ? '0 : wr_q + AW'(do_push);
      rd_d  = iRst ? '0 : rd_q + AW'(do_pop);
      cnt_d = iRst ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge iClk) begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= iData;
   end

endmodule

// File: rtl/eprisc_bus_mailbox.sv
// eprisc_bus_mailbox: 4-word bus window fronting a TX and an RX FIFO, with sticky
// overflow flags, interrupt enables and a registered interrupt request.
module eprisc_bus_mailbox
   import epRISC_bus_pkg::*;
#(
   parameter logic [31:0] BASE  = DEFAULT_BASE,
   parameter int          DEPTH = 16
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic [31:0] iAddr,
   inout  wire  [31:0] bData,
   input  logic        iWrite,
   input  logic        iStb,
   output logic [31:0] oTxData,
   output logic        oTxValid,
   input  logic        iTxReady,
   input  logic [31:0] iRxData,
   input  logic        iRxValid,
   output logic        oRxReady,
   output logic        oInt
);

   localparam int CW = $clog2(DEPTH) + 1;

   reg_off_e      off;
   logic          sel, wr, rd, w1c;
   logic          tx_push, tx_full, tx_empty;
   logic          rx_push, rx_pop, rx_full, rx_empty;
   logic [CW-1:0] tx_count, rx_count;
   logic [31:0]   rx_head, status, rdata;
   logic          rxovf_q, rxovf_d, txovf_q, txovf_d, int_q, int_d;
   logic [1:0]    ctrl_q, ctrl_d;

   // Gating select with reset keeps the bus released and makes a strobe during reset inert.
   assign off     = reg_off_e'(iAddr[1:0]);
   assign sel     = iStb && !iRst && (iAddr[31:2] == BASE[31:2]);
   assign wr      = sel && iWrite;
   assign rd      = sel && !iWrite;
   assign w1c     = wr && off == REG_STATUS;
   assign tx_push = wr && off == REG_DATA;
   assign rx_pop  = rd && off == REG_DATA;
   assign rx_push = iRxValid && !rx_full;

   epRISC_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx (
      .iClk(iClk), .iRst(iRst), .iPush(tx_push), .iPop(iTxReady), .iData(bData),
      .oData(oTxData), .oFull(tx_full), .oEmpty(tx_empty), .oCount(tx_count)
   );

   epRISC_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx (
      .iClk(iClk), .iRst(iRst), .iPush(rx_push), .iPop(rx_pop), .iData(iRxData),
      .oData(rx_head), .oFull(rx_full), .oEmpty(rx_empty), .oCount(rx_count)
   );

   always_comb begin
      status                      = '0;
      status[ST_RXNE]             = !rx_empty;
      status[ST_TXFULL]           = tx_full;
      status[ST_RXOVF]            = rxovf_q;
      status[ST_TXOVF]            = txovf_q;
      status[ST_RXCNT +: ST_CNTW] = ST_CNTW'(rx_count);
      status[ST_TXCNT +: ST_CNTW] = ST_CNTW'(tx_count);
      rdata   = off == REG_DATA   ? (rx_empty ? '0 : rx_head) :
                off == REG_STATUS ? status :
                off == REG_CTRL   ? {30'b0, ctrl_q} : '0;
      // A fresh overflow wins over a same-cycle clear.
      txovf_d = iRst ? 1'b0 : (tx_push && tx_full) || (txovf_q && !(w1c && bData[ST_TXOVF]));
      rxovf_d = iRst ? 1'b0 : (iRxValid && rx_full) || (rxovf_q && !(w1c && bData[ST_RXOVF]));
      ctrl_d  = iRst ? '0 : (wr && off == REG_CTRL) ? bData[CTRL_TXEIE:CTRL_RXIE] : ctrl_q;
      int_d   = iRst ? 1'b0 : (ctrl_q[CTRL_RXIE] && !rx_empty) || (ctrl_q[CTRL_TXEIE] && tx_empty);
   end

   always_ff @(posedge iClk) begin
      txovf_q <= txovf_d;
      rxovf_q <= rxovf_d;
      ctrl_q  <= ctrl_d;
      int_q   <= int_d;
   end

   assign bData    = rd ? rdata : 'z;
   assign oTxValid = !tx_empty;
   assign oRxReady = !rx_full;
   assign oInt     = int_q;

endmodule

// File: doc/eprisc_bus_mailbox.md
EPRISC_BUS_MAILBOX -- requirements
Module: epRISC_bus_mailbox

Interface
REQ-001 The block SHALL have parameter BASE, default 32'hFFFF_0000, giving the word address of a 4-word register window.
REQ-002 The block SHALL have parameter DEPTH, default 16 (power of 2, min 2), giving the entry count of each FIFO.
REQ-003 Port iClk, input, 1: clock, all state on posedge.
REQ-004 Port iRst, input, 1: reset, synchronous, active-high.
REQ-005 Port iAddr, input, 32: bus word address from initiator.
REQ-006 Port bData, inout, 32: bus data; initiator drives on write, block drives on selected read.
REQ-007 Port iWrite, input, 1: 1 = write access, 0 = read access.
REQ-008 Port iStb, input, 1: access qualifier, high exactly one cycle per access.
REQ-009 Port oTxData, output, 32: TX FIFO head word.
REQ-010 Port oTxValid, output, 1: TX FIFO non-empty.
REQ-011 Port iTxReady, input, 1: sink accepts oTxData this cycle.
REQ-012 Port iRxData, input, 32: incoming word.
REQ-013 Port iRxValid, input, 1: iRxData valid.
REQ-014 Port oRxReady, output, 1: RX FIFO not full.
REQ-015 Port oInt, output, 1: registered interrupt request to core iMaskInt.

Function
REQ-016 Select SHALL equal iStb and (iAddr[31:2] == BASE[31:2]); offset is iAddr[1:0].
REQ-017 bData SHALL be driven only when select and not iWrite, else high-Z; read data is combinational from current state (zero wait states).
REQ-018 Offset 0 write SHALL push bData into TX FIFO at the closing posedge; push while full drops the word and sets TXOVF.
REQ-019 Offset 0 read SHALL return RX head and pop it at the closing posedge; read while empty returns 32'h0 with no state change.
REQ-020 Offset 1 read SHALL return STATUS: [0] RX non-empty, [1] TX full, [2] RXOVF, [3] TXOVF, [8:4] RX count, [16:12] TX count, others 0.
REQ-021 Offset 1 write SHALL clear RXOVF/TXOVF where bData[2]/[3] is 1 (W1C); other bits ignored.
REQ-022 Offset 2 SHALL be CTRL, read/write: [0] RXIE, [1] TXEIE; other bits read 0.
REQ-023 Offset 3 SHALL read 32'h0 and ignore writes.
REQ-024 RX push SHALL occur when iRxValid and oRxReady; iRxValid while full sets RXOVF (word lost).
REQ-025 TX pop SHALL occur when oTxValid and iTxReady.
REQ-026 Simultaneous push and pop on one FIFO SHALL leave count unchanged and be lossless; full-FIFO readiness is evaluated before the same-cycle pop.
REQ-027 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH inclusive.
REQ-028 A word written at cycle N SHALL appear on oTxData/oTxValid at cycle N+1; RX word pushed at N SHALL be readable at N+1.
REQ-029 oInt SHALL register (RXIE and RX non-empty) or (TXEIE and TX empty), one-cycle latency.
REQ-030 Overflow and W1C in the same cycle SHALL leave the flag set.

Reset
REQ-031 On iRst, all pointers and counts SHALL be 0, RXOVF/TXOVF/CTRL SHALL be 0, oInt SHALL be 0, oTxValid SHALL be 0, oRxReady SHALL be 1, and bData SHALL be high-Z.
REQ-032 Reset mid-transfer SHALL discard all FIFO contents, and a strobe coincident with iRst SHALL have no effect.

Structure
REQ-033 Package epRISC_bus_pkg SHALL hold register offsets, STATUS/CTRL bit positions, and the default BASE.
REQ-034 One sub-module epRISC_sync_fifo (parameters width and depth, push/pop/full/empty/count) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-035 Write 32'hDEADBEEF to BASE+0 -> next cycle oTxValid=1, oTxData=32'hDEADBEEF; with iTxReady=1 one cycle, oTxValid=0.
REQ-036 Push 16 words with iTxReady=0, then a 17th -> STATUS[1]=1, TXOVF=1, TX count=16; W1C 32'h8 -> TXOVF=0.
REQ-037 iRxValid with 32'h12345678 one cycle, then read BASE+0 -> bData=32'h12345678, following STATUS[0]=0; a second read returns 0.
REQ-038 RX full (16) and iRxValid held -> oRxReady=0, RXOVF=1, then read pop and RX push in the same cycle -> count stays 16 after re-fill, no corruption of order.
REQ-039 CTRL=32'h1 with RX empty, then one RX push -> oInt rises the cycle after push; pop -> oInt falls one cycle later.
REQ-040 Access to BASE+4 (outside window) with iStb -> bData high-Z, no state change; iRst mid-burst -> counts 0, oInt 0.
